// File: rtl/frontend_mode_ctrl.sv
// ---------------------------------------------------------------------------
// frontend_mode_ctrl
//
// Sequencing/configuration controller for the TVP7002 capture frontend.
//  * Once per frame it compares the frontend's sync measurements with a
//    stored reference snapshot. The comparison is debounced into a
//    NOSYNC / ACQUIRE / LOCKED state.
//  * It raises a sticky mode-change interrupt whenever lock is gained or lost.
//  * The CPU stages three configuration words. This block applies all three
//    together at a frame boundary, so the frontend's timing regeneration
//    never sees a half-updated configuration.
//
// Ports
//   PCLK_i               sole clock
//   reset_i              synchronous reset, active-high
//   sync_active_i        frontend sync activity (already in PCLK_i domain)
//   frame_change_i       one-cycle pulse per frame
//   vtotal_i             measured lines per frame
//   pcnt_frame_i         measured ticks per frame
//   hsync_width_i        measured hsync width
//   interlace_flag_i     measured interlace flag
//   cfg_we_i             staging write strobe
//   cfg_sel_i            staging word select (0..2, 3 = ignored)
//   cfg_wdata_i          staging write data
//   commit_req_i         request to apply the staged words
//   irq_ack_i            clears irq_o
//   hv_in_config*_o      applied configuration words
//   commit_pending_o     commit requested but not yet applied
//   commit_done_o        one-cycle pulse when a commit is applied
//   state_o              0 = NOSYNC, 1 = ACQUIRE, 2 = LOCKED
//   locked_vtotal_o      vtotal captured at lock
//   locked_interlace_o   interlace flag captured at lock
//   irq_o                sticky mode-change interrupt
// ---------------------------------------------------------------------------
module frontend_mode_ctrl #(
    parameter int unsigned STABLE_FRAMES = 4,   // 1..15
    parameter int unsigned MISS_FRAMES   = 2,   // 1..15
    parameter int unsigned PCNT_TOL      = 64,
    parameter int unsigned HSW_TOL       = 2
) (
    input  logic        PCLK_i,
    input  logic        reset_i,
    input  logic        sync_active_i,
    input  logic        frame_change_i,
    input  logic [10:0] vtotal_i,
    input  logic [19:0] pcnt_frame_i,
    input  logic [7:0]  hsync_width_i,
    input  logic        interlace_flag_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_sel_i,
    input  logic [31:0] cfg_wdata_i,
    input  logic        commit_req_i,
    input  logic        irq_ack_i,
    output logic [31:0] hv_in_config_o,
    output logic [31:0] hv_in_config2_o,
    output logic [31:0] hv_in_config3_o,
    output logic        commit_pending_o,
    output logic        commit_done_o,
    output logic [1:0]  state_o,
    output logic [10:0] locked_vtotal_o,
    output logic        locked_interlace_o,
    output logic        irq_o
);

    localparam logic [1:0] ST_NOSYNC  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [3:0]  STABLE_LAST = 4'(STABLE_FRAMES - 1);
    localparam logic [3:0]  MISS_LIMIT  = 4'(MISS_FRAMES);
    localparam logic [20:0] PCNT_TOL_W  = 21'(PCNT_TOL);
    localparam logic [8:0]  HSW_TOL_W   = 9'(HSW_TOL);

    // Lock FSM state and counters
    logic [1:0]  state;
    logic [3:0]  stable_cnt;
    logic [3:0]  miss_cnt;

    // Reference snapshot
    logic        snap_valid;
    logic [10:0] snap_vtotal;
    logic [19:0] snap_pcnt;
    logic [7:0]  snap_hsw;
    logic        snap_il;

    // Staged and applied configuration
    logic [31:0] staged_cfg [3];
    logic [31:0] applied_cfg [3];
    logic        pending;
    logic        done;

    logic [10:0] lock_vtotal;
    logic        lock_il;
    logic        irq;

    // Next-state signals
    logic [1:0]  state_nxt;
    logic [3:0]  stable_nxt;
    logic [3:0]  miss_nxt;
    logic        valid_nxt;
    logic        snap_load;
    logic        lock_capture;
    logic        irq_set;

    // Frame comparison
    logic [20:0] pcnt_diff;
    logic [20:0] pcnt_abs;
    logic [8:0]  hsw_diff;
    logic [8:0]  hsw_abs;
    logic        match;
    logic        frame_evt;
    logic        apply;

    // The differences are one bit wider than the operands, so the top bit is
    // the sign. The absolute value always fits in the unsigned result.
    always_comb begin
        pcnt_diff = {1'b0, pcnt_frame_i} - {1'b0, snap_pcnt};
        pcnt_abs  = pcnt_diff[20] ? (~pcnt_diff + 21'd1) : pcnt_diff;
        hsw_diff  = {1'b0, hsync_width_i} - {1'b0, snap_hsw};
        hsw_abs   = hsw_diff[8] ? (~hsw_diff + 9'd1) : hsw_diff;
        match     = (vtotal_i == snap_vtotal) &&
                    (interlace_flag_i == snap_il) &&
                    (pcnt_abs <= PCNT_TOL_W) &&
                    (hsw_abs <= HSW_TOL_W);
    end

    // When sync is lost, the frame event on the same cycle is ignored.
    assign frame_evt = frame_change_i & sync_active_i;

    // In NOSYNC no frame boundary will arrive, so the commit is applied
    // immediately. Otherwise it waits for the next frame event. Because
    // pending is registered, a request that arrives together with a frame
    // event waits for the following frame.
    assign apply = pending & ((state == ST_NOSYNC) | frame_evt);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first.
        // A signal left unassigned on some path would infer a latch.
        state_nxt    = state;
        stable_nxt   = stable_cnt;
        miss_nxt     = miss_cnt;
        valid_nxt    = snap_valid;
        snap_load    = 1'b0;
        lock_capture = 1'b0;
        irq_set      = 1'b0;

        case (state)
            ST_NOSYNC: begin
                stable_nxt = '0;
                miss_nxt   = '0;
                valid_nxt  = 1'b0;
                if (sync_active_i) state_nxt = ST_ACQUIRE;
            end

            ST_ACQUIRE: begin
                if (!sync_active_i) begin
                    state_nxt = ST_NOSYNC;
                end else if (frame_change_i) begin
                    if (!snap_valid) begin
                        snap_load  = 1'b1;
                        valid_nxt  = 1'b1;
                        stable_nxt = '0;
                    end else if (match) begin
                        if (stable_cnt == STABLE_LAST) begin
                            state_nxt    = ST_LOCKED;
                            irq_set      = 1'b1;
                            lock_capture = 1'b1;
                            stable_nxt   = '0;
                            miss_nxt     = '0;
                        end else begin
                            stable_nxt = stable_cnt + 4'd1;
                        end
                    end else begin
                        snap_load  = 1'b1;
                        stable_nxt = '0;
                    end
                end
            end

            ST_LOCKED: begin
                if (!sync_active_i) begin
                    state_nxt = ST_NOSYNC;
                    irq_set   = 1'b1;
                    miss_nxt  = '0;
                end else if (frame_change_i) begin
                    if (match) begin
                        miss_nxt = '0;
                    end else if (miss_cnt + 4'd1 == MISS_LIMIT) begin
                        // Lock is lost: start acquiring again from this frame.
                        state_nxt  = ST_ACQUIRE;
                        irq_set    = 1'b1;
                        snap_load  = 1'b1;
                        valid_nxt  = 1'b1;
                        stable_nxt = '0;
                        miss_nxt   = '0;
                    end else begin
                        miss_nxt = miss_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = ST_NOSYNC;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples values from before the edge, in any evaluation order.
    always_ff @(posedge PCLK_i) begin
        if (reset_i) begin
            state        <= ST_NOSYNC;
            stable_cnt   <= '0;
            miss_cnt     <= '0;
            snap_valid   <= 1'b0;
            snap_vtotal  <= '0;
            snap_pcnt    <= '0;
            snap_hsw     <= '0;
            snap_il      <= 1'b0;
            lock_vtotal  <= '0;
            lock_il      <= 1'b0;
            irq          <= 1'b0;
            pending      <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                staged_cfg[i]  <= '0;
                applied_cfg[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            stable_cnt <= stable_nxt;
            miss_cnt   <= miss_nxt;
            snap_valid <= valid_nxt;

            if (snap_load) begin
                snap_vtotal <= vtotal_i;
                snap_pcnt   <= pcnt_frame_i;
                snap_hsw    <= hsync_width_i;
                snap_il     <= interlace_flag_i;
            end

            if (lock_capture) begin
                lock_vtotal <= snap_vtotal;
                lock_il     <= snap_il;
            end

            // If a set and an acknowledge arrive on the same cycle, the set wins.
            irq <= irq_set | (irq & ~irq_ack_i);

            if (cfg_we_i && cfg_sel_i != 2'd3) begin
                staged_cfg[cfg_sel_i] <= cfg_wdata_i;
            end

            // The applied words read the staged registers as they were before
            // this edge. A write on the apply cycle therefore stays staged for
            // the next commit.
            if (apply) begin
                for (int i = 0; i < 3; i++) applied_cfg[i] <= staged_cfg[i];
            end
            done    <= apply;
            pending <= commit_req_i | (pending & ~apply);
        end
    end

    assign hv_in_config_o     = applied_cfg[0];
    assign hv_in_config2_o    = applied_cfg[1];
    assign hv_in_config3_o    = applied_cfg[2];
    assign commit_pending_o   = pending;
    assign commit_done_o      = done;
    assign state_o            = state;
    assign locked_vtotal_o    = lock_vtotal;
    assign locked_interlace_o = lock_il;
    assign irq_o              = irq;

endmodule

// File: tb/tb_frontend_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frontend_mode_ctrl
//
// Directed testbench for frontend_mode_ctrl. Inputs change 1 ns after a
// rising edge. Outputs are sampled 1 ns after the edge that consumed them.
// ---------------------------------------------------------------------------
module tb_frontend_mode_ctrl;

    logic        PCLK_i = 1'b0;
    logic        reset_i;
    logic        sync_active_i;
    logic        frame_change_i;
    logic [10:0] vtotal_i;
    logic [19:0] pcnt_frame_i;
    logic [7:0]  hsync_width_i;
    logic        interlace_flag_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_sel_i;
    logic [31:0] cfg_wdata_i;
    logic        commit_req_i;
    logic        irq_ack_i;
    logic [31:0] hv_in_config_o;
    logic [31:0] hv_in_config2_o;
    logic [31:0] hv_in_config3_o;
    logic        commit_pending_o;
    logic        commit_done_o;
    logic [1:0]  state_o;
    logic [10:0] locked_vtotal_o;
    logic        locked_interlace_o;
    logic        irq_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 PCLK_i = ~PCLK_i;

    frontend_mode_ctrl dut (
        .PCLK_i             (PCLK_i),
        .reset_i            (reset_i),
        .sync_active_i      (sync_active_i),
        .frame_change_i     (frame_change_i),
        .vtotal_i           (vtotal_i),
        .pcnt_frame_i       (pcnt_frame_i),
        .hsync_width_i      (hsync_width_i),
        .interlace_flag_i   (interlace_flag_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_sel_i          (cfg_sel_i),
        .cfg_wdata_i        (cfg_wdata_i),
        .commit_req_i       (commit_req_i),
        .irq_ack_i          (irq_ack_i),
        .hv_in_config_o     (hv_in_config_o),
        .hv_in_config2_o    (hv_in_config2_o),
        .hv_in_config3_o    (hv_in_config3_o),
        .commit_pending_o   (commit_pending_o),
        .commit_done_o      (commit_done_o),
        .state_o            (state_o),
        .locked_vtotal_o    (locked_vtotal_o),
        .locked_interlace_o (locked_interlace_o),
        .irq_o              (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic frame(input logic [10:0] vt, input logic [19:0] pc, input logic [7:0] hw);
        vtotal_i         = vt;
        pcnt_frame_i     = pc;
        hsync_width_i    = hw;
        interlace_flag_i = 1'b0;
        frame_change_i   = 1'b1;
        tick();
        frame_change_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_sel_i   = sel;
        cfg_wdata_i = data;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic ack_irq();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    // Bounds the run even if something upstream stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; sync_active_i = 1'b0; frame_change_i = 1'b0;
        vtotal_i = '0; pcnt_frame_i = '0; hsync_width_i = '0; interlace_flag_i = 1'b0;
        cfg_we_i = 1'b0; cfg_sel_i = '0; cfg_wdata_i = '0;
        commit_req_i = 1'b0; irq_ack_i = 1'b0;
        #1;
        idle(2);
        reset_i = 1'b0;

        // Reset state
        check("rst_state",   32'(state_o), 32'd0);
        check("rst_irq",     32'(irq_o), 32'd0);
        check("rst_cfg0",    hv_in_config_o, 32'd0);
        check("rst_pending", 32'(commit_pending_o), 32'd0);
        check("rst_done",    32'(commit_done_o), 32'd0);
        check("rst_lvt",     32'(locked_vtotal_o), 32'd0);

        // Acquire and lock: 525 lines, lock after the 5th frame
        sync_active_i = 1'b1;
        tick();
        check("acq_enter", 32'(state_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            frame(11'd525, 20'd450450, 8'd64);
            idle(2);
        end
        check("acq_after4", 32'(state_o), 32'd1);
        check("acq_irq0",   32'(irq_o), 32'd0);
        frame(11'd525, 20'd450450, 8'd64);
        check("lock_state", 32'(state_o), 32'd2);
        check("lock_irq",   32'(irq_o), 32'd1);
        check("lock_vt",    32'(locked_vtotal_o), 32'd525);
        check("lock_il",    32'(locked_interlace_o), 32'd0);
        ack_irq();
        check("ack_clears", 32'(irq_o), 32'd0);

        // Jitter within tolerance keeps lock (+60 ticks, +2 / -2 hsync)
        frame(11'd525, 20'd450510, 8'd66); idle(2);
        frame(11'd525, 20'd450450, 8'd64); idle(2);
        frame(11'd525, 20'd450510, 8'd66); idle(2);
        frame(11'd525, 20'd450450, 8'd62); idle(2);
        check("jit_state", 32'(state_o), 32'd2);
        check("jit_irq",   32'(irq_o), 32'd0);
        // +70 ticks exceeds tolerance: two misses drop lock
        frame(11'd525, 20'd450520, 8'd64); idle(2);
        check("tol_miss1", 32'(state_o), 32'd2);
        frame(11'd525, 20'd450520, 8'd64);
        check("tol_drop",     32'(state_o), 32'd1);
        check("tol_drop_irq", 32'(irq_o), 32'd1);
        ack_irq();
        // The snapshot was reloaded at 450520; 4 matching frames relock
        for (int i = 0; i < 3; i++) begin
            frame(11'd525, 20'd450520, 8'd64);
            idle(2);
        end
        check("relock_pre", 32'(state_o), 32'd1);
        frame(11'd525, 20'd450520, 8'd64);
        check("relock", 32'(state_o), 32'd2);
        ack_irq();

        // Single glitch, recovery clears miss_cnt, then one more glitch
        frame(11'd263, 20'd450520, 8'd64); idle(2);
        frame(11'd525, 20'd450520, 8'd64); idle(2);
        frame(11'd263, 20'd450520, 8'd64); idle(2);
        check("glitch_hold", 32'(state_o), 32'd2);
        check("glitch_irq",  32'(irq_o), 32'd0);
        frame(11'd263, 20'd450520, 8'd64);
        check("glitch2_drop", 32'(state_o), 32'd1);
        check("glitch2_irq",  32'(irq_o), 32'd1);
        check("glitch2_lvt",  32'(locked_vtotal_o), 32'd525);
        ack_irq();
        for (int i = 0; i < 3; i++) begin
            frame(11'd263, 20'd450520, 8'd64);
            idle(2);
        end
        check("lock263_pre", 32'(state_o), 32'd1);
        frame(11'd263, 20'd450520, 8'd64);
        check("lock263",     32'(state_o), 32'd2);
        check("lock263_lvt", 32'(locked_vtotal_o), 32'd263);
        ack_irq();

        // Commit in LOCKED: staged words wait for the next frame event
        cfg_write(2'd0, 32'hA);
        cfg_write(2'd1, 32'hB);
        cfg_write(2'd2, 32'hC);
        cfg_write(2'd3, 32'hDEAD);
        commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
        check("cm_pending", 32'(commit_pending_o), 32'd1);
        commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;  // merged request
        idle(2);
        check("cm_hold0", hv_in_config_o, 32'd0);
        check("cm_hold2", hv_in_config3_o, 32'd0);
        // Apply frame, with a write on the same cycle that must stay staged
        cfg_we_i = 1'b1; cfg_sel_i = 2'd0; cfg_wdata_i = 32'h55;
        frame(11'd263, 20'd450520, 8'd64);
        cfg_we_i = 1'b0;
        check("cm_cfg0",   hv_in_config_o, 32'hA);
        check("cm_cfg1",   hv_in_config2_o, 32'hB);
        check("cm_cfg2",   hv_in_config3_o, 32'hC);
        check("cm_done",   32'(commit_done_o), 32'd1);
        check("cm_pend0",  32'(commit_pending_o), 32'd0);
        tick();
        check("cm_done_pulse", 32'(commit_done_o), 32'd0);
        check("cm_cfg0_keep",  hv_in_config_o, 32'hA);

        // Commit request together with a frame event waits for the next one
        commit_req_i = 1'b1;
        frame(11'd263, 20'd450520, 8'd64);
        commit_req_i = 1'b0;
        check("cmf_nodone", 32'(commit_done_o), 32'd0);
        check("cmf_pend",   32'(commit_pending_o), 32'd1);
        check("cmf_cfg0",   hv_in_config_o, 32'hA);
        idle(2);
        frame(11'd263, 20'd450520, 8'd64);
        check("cmf_done", 32'(commit_done_o), 32'd1);
        check("cmf_cfg0_new", hv_in_config_o, 32'h55);

        // Sync loss on a frame-event cycle, with a commit pending
        cfg_write(2'd2, 32'h77);
        commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
        sync_active_i = 1'b0;
        frame(11'd100, 20'd1000, 8'd10);
        check("loss_state",  32'(state_o), 32'd0);
        check("loss_irq",    32'(irq_o), 32'd1);
        check("loss_nodone", 32'(commit_done_o), 32'd0);
        check("loss_cfg2",   hv_in_config3_o, 32'hC);
        tick();
        check("nosync_done", 32'(commit_done_o), 32'd1);
        check("nosync_cfg2", hv_in_config3_o, 32'h77);
        check("nosync_pend", 32'(commit_pending_o), 32'd0);
        ack_irq();

        // Acknowledge on the same cycle as a lock event: the set wins
        sync_active_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            frame(11'd525, 20'd450450, 8'd64);
            idle(2);
        end
        irq_ack_i = 1'b1;
        frame(11'd525, 20'd450450, 8'd64);
        irq_ack_i = 1'b0;
        check("ackset_state", 32'(state_o), 32'd2);
        check("ackset_irq",   32'(irq_o), 32'd1);

        // Reset while a commit is pending
        commit_req_i = 1'b1; tick(); commit_req_i = 1'b0;
        check("rp_pending", 32'(commit_pending_o), 32'd1);
        reset_i = 1'b1;
        tick();
        check("rp_pend0", 32'(commit_pending_o), 32'd0);
        check("rp_cfg0",  hv_in_config_o, 32'd0);
        check("rp_cfg2",  hv_in_config3_o, 32'd0);
        check("rp_state", 32'(state_o), 32'd0);
        check("rp_irq",   32'(irq_o), 32'd0);
        reset_i = 1'b0;
        tick();
        check("rp_nodone", 32'(commit_done_o), 32'd0);
        check("rp_cfg1",   hv_in_config2_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
